uart_rx_ctrl: RTL and testbench

- Sequences the UART receive path between the bit-level receiver and the RX FIFO.
- On each character-complete pulse: captures the data byte and error flags, then writes them as one FIFO entry. If the FIFO is full, the character is dropped and overrun is flagged.
- Generates the "received data available" (RDA) trigger-level indication and the 4-character-time receive timeout (CTO) used by the interrupt logic in the APB UART top.

---
 rtl/uart_rx_ctrl_if.sv | 38 +++
 rtl/uart_rx_ctrl.sv | 117 +++++++++++
 tb/tb_uart_rx_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_if.sv
// Receiver/FIFO/interrupt-side signal bundle for the UART receive controller.
// The master side drives receiver, config and FIFO status; the slave side is uart_rx_ctrl.
interface uart_rx_ctrl_if #(
    parameter int USAGE_W = 5
);
    logic               RX_EN;
    logic               BAUDCE;
    logic               RXFINISHED;
    logic [7:0]         DOUT;
    logic               PE;
    logic               FE;
    logic               BI;
    logic [1:0]         WLS;
    logic               STB;
    logic               PEN;
    logic               FIFO_EN;
    logic [1:0]         RXTRIG;
    logic [USAGE_W-1:0] FIFO_USAGE;
    logic               FIFO_READ;
    logic               LSR_READ;
    logic               FIFO_WRITE;
    logic [10:0]        FIFO_WDATA;
    logic               OE;
    logic               RDA;
    logic               CTO;

    modport master (
        output RX_EN, BAUDCE, RXFINISHED, DOUT, PE, FE, BI, WLS, STB, PEN,
               FIFO_EN, RXTRIG, FIFO_USAGE, FIFO_READ, LSR_READ,
        input  FIFO_WRITE, FIFO_WDATA, OE, RDA, CTO
    );

    modport slave (
        input  RX_EN, BAUDCE, RXFINISHED, DOUT, PE, FE, BI, WLS, STB, PEN,
               FIFO_EN, RXTRIG, FIFO_USAGE, FIFO_READ, LSR_READ,
        output FIFO_WRITE, FIFO_WDATA, OE, RDA, CTO
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART RX sequencer: captures each received character into the RX FIFO (1 cycle after RXFINISHED), plus RDA and CTO.
// No backpressure: a character arriving to a full FIFO (or during a push) is dropped and OE is flagged.
module uart_rx_ctrl #(
    parameter int FIFO_DEPTH = 16,
    parameter int USAGE_W    = 5
) (
    input  logic          CLK,
    input  logic          RSTN,
    uart_rx_ctrl_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        PUSH = 1'b1
    } state_t;

    localparam logic [USAGE_W-1:0] DEPTH_U = USAGE_W'(FIFO_DEPTH);

    state_t      state;
    state_t      state_nxt;
    logic [10:0] cap_q;
    logic [10:0] wdata_q;
    logic        oe_q;
    logic        cto_q;
    logic [9:0]  to_cnt;

    logic        full;
    logic        capture;
    logic        fifo_write;
    logic        oe_set;
    logic        to_clr;
    logic [3:0]  char_bits;
    logic [9:0]  to_limit;
    logic [9:0]  to_limit_m1;
    logic [USAGE_W-1:0] trig_lvl;

    // Holding-register mode treats any occupancy as full.
    always_comb begin
        if (bus.FIFO_EN) full = (bus.FIFO_USAGE >= DEPTH_U);
        else             full = (bus.FIFO_USAGE != '0);
    end

    always_comb begin
        state_nxt  = state;
        capture    = 1'b0;
        fifo_write = 1'b0;
        oe_set     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.RXFINISHED && bus.RX_EN) begin
                    capture   = 1'b1;
                    state_nxt = PUSH;
                end
            end
            PUSH: begin
                fifo_write = !full;
                oe_set     = full || (bus.RXFINISHED && bus.RX_EN);
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (!bus.RX_EN) state_nxt = IDLE;
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state   <= IDLE;
            cap_q   <= '0;
            wdata_q <= '0;
            oe_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (capture)          cap_q   <= {bus.BI, bus.FE, bus.PE, bus.DOUT};
            if (fifo_write)       wdata_q <= cap_q;
            if (oe_set)           oe_q    <= 1'b1;
            else if (bus.LSR_READ) oe_q   <= 1'b0;
        end
    end

    assign bus.FIFO_WRITE = fifo_write;
    assign bus.FIFO_WDATA = fifo_write ? cap_q : wdata_q;
    assign bus.OE         = oe_q;

    always_comb begin
        trig_lvl = USAGE_W'(1);
        case (bus.RXTRIG)
            2'b00: trig_lvl = USAGE_W'(1);
            2'b01: trig_lvl = USAGE_W'(4);
            2'b10: trig_lvl = USAGE_W'(8);
            2'b11: trig_lvl = USAGE_W'(14);
            default: trig_lvl = USAGE_W'(1);
        endcase
    end

    assign bus.RDA = bus.FIFO_EN ? (bus.FIFO_USAGE >= trig_lvl) : (bus.FIFO_USAGE != '0);

    // Four character times of 16x ticks: bits * 16 * 4.
    assign char_bits   = 4'd7 + {2'b00, bus.WLS} + {3'b000, bus.PEN} + {3'b000, bus.STB};
    assign to_limit    = {char_bits, 6'b000000};
    assign to_limit_m1 = to_limit - 10'd1;
    assign to_clr      = fifo_write || bus.FIFO_READ || (bus.FIFO_USAGE == '0) || !bus.RX_EN;

    // >= rather than == so a shrinking LIMIT still fires on the next tick.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            to_cnt <= '0;
            cto_q  <= 1'b0;
        end else if (to_clr) begin
            to_cnt <= '0;
            cto_q  <= 1'b0;
        end else if (bus.BAUDCE && !cto_q) begin
            if (to_cnt >= to_limit_m1) cto_q  <= 1'b1;
            else                       to_cnt <= to_cnt + 10'd1;
        end
    end

    assign bus.CTO = cto_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;
    logic CLK = 1'b0;
    logic RSTN = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [10:0] last_w = '0;
    logic        oe_m = 1'b0;

    always #5 CLK = ~CLK;

    uart_rx_ctrl_if #(.USAGE_W(5)) bus ();

    uart_rx_ctrl #(.FIFO_DEPTH(16), .USAGE_W(5)) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus)
    );

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    function automatic int lim_of(input int wls, input int pen, input int stb);
        return (1 + (5 + wls) + pen + (1 + stb)) * 64;
    endfunction

    task automatic set_cfg(input logic [1:0] wls, input logic pen, input logic stb);
        bus.WLS = wls;
        bus.PEN = pen;
        bus.STB = stb;
    endtask

    task automatic test_reset();
        RSTN = 1'b0;
        repeat (3) cyc();
        checks++; if (bus.FIFO_WRITE !== 1'b0) begin errors++; $display("FAIL rst_write got %b want 0", bus.FIFO_WRITE); end
        checks++; if (bus.FIFO_WDATA !== 11'h000) begin errors++; $display("FAIL rst_wdata got %h want 000", bus.FIFO_WDATA); end
        checks++; if (bus.OE !== 1'b0) begin errors++; $display("FAIL rst_oe got %b want 0", bus.OE); end
        checks++; if (bus.CTO !== 1'b0) begin errors++; $display("FAIL rst_cto got %b want 0", bus.CTO); end
        RSTN = 1'b1;
        cyc();
    endtask

    task automatic test_push_basic();
        bus.FIFO_EN = 1'b1; bus.FIFO_USAGE = 5'd0;
        bus.DOUT = 8'h5A; bus.PE = 1'b1; bus.FE = 1'b0; bus.BI = 1'b0;
        bus.RXFINISHED = 1'b1;
        cyc();
        bus.RXFINISHED = 1'b0; bus.DOUT = 8'hFF; bus.PE = 1'b0;
        #1;
        checks++; if (bus.FIFO_WRITE !== 1'b1) begin errors++; $display("FAIL basic_write got %b want 1", bus.FIFO_WRITE); end
        checks++; if (bus.FIFO_WDATA !== 11'h15A) begin errors++; $display("FAIL basic_wdata got %h want 15a", bus.FIFO_WDATA); end
        last_w = 11'h15A;
        cyc();
        checks++; if (bus.FIFO_WRITE !== 1'b0) begin errors++; $display("FAIL basic_single got %b want 0", bus.FIFO_WRITE); end
        checks++; if (bus.FIFO_WDATA !== last_w) begin errors++; $display("FAIL basic_hold got %h want %h", bus.FIFO_WDATA, last_w); end
    endtask

    task automatic test_push_random();
        for (int i = 0; i < 30; i++) begin
            logic [7:0] d;
            logic pe, fe, bi, fen, full, lsr;
            logic [4:0] use_n;
            d = 8'($urandom); pe = 1'($urandom); fe = 1'($urandom); bi = 1'($urandom);
            fen = 1'($urandom);
            use_n = 5'($urandom_range(0, 16));
            full = fen ? (use_n >= 5'd16) : (use_n != 5'd0);
            bus.DOUT = d; bus.PE = pe; bus.FE = fe; bus.BI = bi;
            bus.FIFO_EN = fen; bus.FIFO_USAGE = use_n;
            bus.RXFINISHED = 1'b1;
            cyc();
            bus.RXFINISHED = 1'b0; bus.DOUT = ~d; bus.PE = ~pe;
            #1;
            checks++; if (bus.FIFO_WRITE !== !full) begin errors++; $display("FAIL rnd_write[%0d] got %b want %b", i, bus.FIFO_WRITE, !full); end
            if (!full) last_w = {bi, fe, pe, d};
            else       oe_m = 1'b1;
            checks++; if (bus.FIFO_WDATA !== last_w) begin errors++; $display("FAIL rnd_wdata[%0d] got %h want %h", i, bus.FIFO_WDATA, last_w); end
            cyc();
            checks++; if (bus.OE !== oe_m) begin errors++; $display("FAIL rnd_oe[%0d] got %b want %b", i, bus.OE, oe_m); end
            lsr = 1'($urandom);
            if (lsr) begin
                bus.LSR_READ = 1'b1;
                cyc();
                bus.LSR_READ = 1'b0;
                oe_m = 1'b0;
                checks++; if (bus.OE !== 1'b0) begin errors++; $display("FAIL rnd_oeclr[%0d] got %b want 0", i, bus.OE); end
            end
        end
        bus.LSR_READ = 1'b1; cyc(); bus.LSR_READ = 1'b0; oe_m = 1'b0;
    endtask

    task automatic test_overrun();
        bus.FIFO_EN = 1'b1; bus.FIFO_USAGE = 5'd16;
        bus.DOUT = 8'h33; bus.PE = 1'b0; bus.FE = 1'b0; bus.BI = 1'b0;
        bus.RXFINISHED = 1'b1;
        cyc();
        bus.RXFINISHED = 1'b0;
        #1;
        checks++; if (bus.FIFO_WRITE !== 1'b0) begin errors++; $display("FAIL ovr_nowrite got %b want 0", bus.FIFO_WRITE); end
        checks++; if (bus.FIFO_WDATA !== last_w) begin errors++; $display("FAIL ovr_hold got %h want %h", bus.FIFO_WDATA, last_w); end
        cyc();
        checks++; if (bus.OE !== 1'b1) begin errors++; $display("FAIL ovr_oe got %b want 1", bus.OE); end
        bus.LSR_READ = 1'b1; cyc(); bus.LSR_READ = 1'b0;
        checks++; if (bus.OE !== 1'b0) begin errors++; $display("FAIL ovr_lsrclr got %b want 0", bus.OE); end
        // set and clear in the same cycle
        bus.RXFINISHED = 1'b1; cyc(); bus.RXFINISHED = 1'b0;
        bus.LSR_READ = 1'b1; cyc(); bus.LSR_READ = 1'b0;
        checks++; if (bus.OE !== 1'b1) begin errors++; $display("FAIL ovr_setwins got %b want 1", bus.OE); end
        bus.LSR_READ = 1'b1; cyc(); bus.LSR_READ = 1'b0;
        // pop coincident with a full push still drops
        bus.RXFINISHED = 1'b1; cyc(); bus.RXFINISHED = 1'b0;
        bus.FIFO_READ = 1'b1; #1;
        checks++; if (bus.FIFO_WRITE !== 1'b0) begin errors++; $display("FAIL ovr_readsame got %b want 0", bus.FIFO_WRITE); end
        cyc(); bus.FIFO_READ = 1'b0;
        checks++; if (bus.OE !== 1'b1) begin errors++; $display("FAIL ovr_readsame_oe got %b want 1", bus.OE); end
        bus.LSR_READ = 1'b1; cyc(); bus.LSR_READ = 1'b0;
        // second character arriving during the push is lost
        bus.FIFO_USAGE = 5'd0;
        bus.DOUT = 8'hA1; bus.RXFINISHED = 1'b1; cyc();
        bus.DOUT = 8'h7E; #1;
        checks++; if (bus.FIFO_WRITE !== 1'b1 || bus.FIFO_WDATA !== 11'h0A1) begin errors++; $display("FAIL ovr_inpush_w got %b/%h want 1/0a1", bus.FIFO_WRITE, bus.FIFO_WDATA); end
        last_w = 11'h0A1;
        cyc(); bus.RXFINISHED = 1'b0; #1;
        checks++; if (bus.FIFO_WRITE !== 1'b0 || bus.OE !== 1'b1) begin errors++; $display("FAIL ovr_inpush_lost got w=%b oe=%b want w=0 oe=1", bus.FIFO_WRITE, bus.OE); end
        bus.LSR_READ = 1'b1; cyc(); bus.LSR_READ = 1'b0; oe_m = 1'b0;
    endtask

    task automatic test_rda();
        int trig [4] = '{1, 4, 8, 14};
        bus.FIFO_EN = 1'b1; bus.RXTRIG = 2'b10;
        bus.FIFO_USAGE = 5'd7; #1;
        checks++; if (bus.RDA !== 1'b0) begin errors++; $display("FAIL rda_7 got %b want 0", bus.RDA); end
        bus.FIFO_USAGE = 5'd8; #1;
        checks++; if (bus.RDA !== 1'b1) begin errors++; $display("FAIL rda_8 got %b want 1", bus.RDA); end
        bus.FIFO_EN = 1'b0; bus.FIFO_USAGE = 5'd1; #1;
        checks++; if (bus.RDA !== 1'b1) begin errors++; $display("FAIL rda_hold got %b want 1", bus.RDA); end
        for (int i = 0; i < 40; i++) begin
            logic fen, exp;
            logic [1:0] tr;
            int u;
            fen = 1'($urandom); tr = 2'($urandom); u = $urandom_range(0, 16);
            bus.FIFO_EN = fen; bus.RXTRIG = tr; bus.FIFO_USAGE = 5'(u);
            #1;
            exp = fen ? (u >= trig[tr]) : (u != 0);
            checks++; if (bus.RDA !== exp) begin errors++; $display("FAIL rda_rnd[%0d] got %b want %b", i, bus.RDA, exp); end
        end
        // holding-register mode with one entry drops the next character
        bus.FIFO_EN = 1'b0; bus.FIFO_USAGE = 5'd1;
        cyc();
        bus.RXFINISHED = 1'b1; cyc(); bus.RXFINISHED = 1'b0; #1;
        checks++; if (bus.FIFO_WRITE !== 1'b0) begin errors++; $display("FAIL hold_drop got %b want 0", bus.FIFO_WRITE); end
        cyc();
        checks++; if (bus.OE !== 1'b1) begin errors++; $display("FAIL hold_oe got %b want 1", bus.OE); end
        bus.LSR_READ = 1'b1; cyc(); bus.LSR_READ = 1'b0;
        bus.FIFO_EN = 1'b1;
    endtask

    task automatic test_timeout();
        set_cfg(2'b11, 1'b0, 1'b0);
        bus.FIFO_EN = 1'b1; bus.FIFO_USAGE = 5'd0; cyc();
        bus.FIFO_USAGE = 5'd1; bus.BAUDCE = 1'b1;
        repeat (639) cyc();
        checks++; if (bus.CTO !== 1'b0) begin errors++; $display("FAIL cto_639 got %b want 0", bus.CTO); end
        cyc();
        checks++; if (bus.CTO !== 1'b1) begin errors++; $display("FAIL cto_640 got %b want 1", bus.CTO); end
        repeat (5) cyc();
        checks++; if (bus.CTO !== 1'b1) begin errors++; $display("FAIL cto_sticky got %b want 1", bus.CTO); end
        bus.BAUDCE = 1'b0; bus.FIFO_READ = 1'b1; cyc(); bus.FIFO_READ = 1'b0;
        checks++; if (bus.CTO !== 1'b0) begin errors++; $display("FAIL cto_readclr got %b want 0", bus.CTO); end
        bus.BAUDCE = 1'b1;
        repeat (639) cyc();
        checks++; if (bus.CTO !== 1'b0) begin errors++; $display("FAIL cto_restart639 got %b want 0", bus.CTO); end
        cyc();
        checks++; if (bus.CTO !== 1'b1) begin errors++; $display("FAIL cto_restart640 got %b want 1", bus.CTO); end
        // shrinking the frame below the elapsed count fires on the next tick
        bus.BAUDCE = 1'b0; bus.FIFO_USAGE = 5'd0; cyc(); bus.FIFO_USAGE = 5'd1;
        bus.BAUDCE = 1'b1; repeat (600) cyc(); bus.BAUDCE = 1'b0;
        set_cfg(2'b00, 1'b0, 1'b0);
        cyc();
        checks++; if (bus.CTO !== 1'b0) begin errors++; $display("FAIL cto_shrink_wait got %b want 0", bus.CTO); end
        bus.BAUDCE = 1'b1; cyc(); bus.BAUDCE = 1'b0;
        checks++; if (bus.CTO !== 1'b1) begin errors++; $display("FAIL cto_shrink_fire got %b want 1", bus.CTO); end
    endtask

    task automatic test_timeout_random();
        for (int r = 0; r < 3; r++) begin
            int wls, pen, stb, lim, ticks;
            int bad = 0;
            wls = $urandom_range(0, 3); pen = $urandom_range(0, 1); stb = $urandom_range(0, 1);
            lim = lim_of(wls, pen, stb);
            set_cfg(2'(wls), 1'(pen), 1'(stb));
            bus.BAUDCE = 1'b0; bus.FIFO_READ = 1'b0;
            bus.FIFO_USAGE = 5'd0; cyc(); bus.FIFO_USAGE = 5'd1;
            ticks = 0;
            for (int c = 0; c < 2 * lim; c++) begin
                logic b, rd, exp;
                b = ($urandom_range(0, 3) != 0);
                rd = ($urandom_range(0, 299) == 0);
                bus.BAUDCE = b; bus.FIFO_READ = rd;
                cyc();
                if (rd) ticks = 0;
                else if (b) ticks++;
                exp = (ticks >= lim);
                checks++;
                if (bus.CTO !== exp) begin
                    errors++;
                    if (bad < 5) $display("FAIL cto_rnd[%0d/%0d] got %b want %b ticks=%0d lim=%0d", r, c, bus.CTO, exp, ticks, lim);
                    bad++;
                end
            end
            bus.BAUDCE = 1'b0; bus.FIFO_READ = 1'b0;
        end
    endtask

    task automatic test_write_restart();
        set_cfg(2'b00, 1'b1, 1'b1);
        bus.FIFO_EN = 1'b1; bus.FIFO_USAGE = 5'd0; cyc(); bus.FIFO_USAGE = 5'd1;
        bus.BAUDCE = 1'b1; repeat (300) cyc(); bus.BAUDCE = 1'b0;
        bus.DOUT = 8'h96; bus.PE = 1'b0; bus.FE = 1'b1; bus.BI = 1'b0;
        bus.RXFINISHED = 1'b1; cyc(); bus.RXFINISHED = 1'b0; #1;
        checks++; if (bus.FIFO_WRITE !== 1'b1 || bus.FIFO_WDATA !== 11'h296) begin errors++; $display("FAIL wr_push got %b/%h want 1/296", bus.FIFO_WRITE, bus.FIFO_WDATA); end
        last_w = 11'h296;
        cyc();
        bus.BAUDCE = 1'b1; repeat (575) cyc();
        checks++; if (bus.CTO !== 1'b0) begin errors++; $display("FAIL wr_cto575 got %b want 0", bus.CTO); end
        cyc(); bus.BAUDCE = 1'b0;
        checks++; if (bus.CTO !== 1'b1) begin errors++; $display("FAIL wr_cto576 got %b want 1", bus.CTO); end
    endtask

    task automatic test_rx_disable();
        bus.RX_EN = 1'b0; cyc();
        checks++; if (bus.CTO !== 1'b0) begin errors++; $display("FAIL dis_ctoclr got %b want 0", bus.CTO); end
        bus.FIFO_USAGE = 5'd1; bus.BAUDCE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.RXFINISHED = 1'b1; cyc(); bus.RXFINISHED = 1'b0; #1;
            checks++; if (bus.FIFO_WRITE !== 1'b0) begin errors++; $display("FAIL dis_nowrite[%0d] got %b want 0", i, bus.FIFO_WRITE); end
            cyc();
        end
        repeat (700) cyc();
        checks++; if (bus.CTO !== 1'b0 || bus.OE !== 1'b0) begin errors++; $display("FAIL dis_idle got cto=%b oe=%b want 0/0", bus.CTO, bus.OE); end
        bus.RX_EN = 1'b1;
        repeat (700) cyc();
        checks++; if (bus.CTO !== 1'b1) begin errors++; $display("FAIL dis_reen got %b want 1", bus.CTO); end
        bus.BAUDCE = 1'b0;
    endtask

    task automatic test_reset_in_push();
        bus.FIFO_EN = 1'b1; bus.FIFO_USAGE = 5'd1;
        bus.DOUT = 8'hC3; bus.PE = 1'b0; bus.FE = 1'b0; bus.BI = 1'b1;
        bus.RXFINISHED = 1'b1; cyc(); bus.RXFINISHED = 1'b0;
        RSTN = 1'b0; #1;
        checks++; if (bus.FIFO_WRITE !== 1'b1) begin errors++; $display("FAIL rp_inpush got %b want 1", bus.FIFO_WRITE); end
        cyc();
        checks++; if (bus.FIFO_WRITE !== 1'b0 || bus.FIFO_WDATA !== 11'h000) begin errors++; $display("FAIL rp_after got %b/%h want 0/000", bus.FIFO_WRITE, bus.FIFO_WDATA); end
        checks++; if (bus.CTO !== 1'b0 || bus.OE !== 1'b0) begin errors++; $display("FAIL rp_flags got cto=%b oe=%b want 0/0", bus.CTO, bus.OE); end
        RSTN = 1'b1; last_w = 11'h000; oe_m = 1'b0;
        cyc();
        bus.DOUT = 8'h0F; bus.BI = 1'b0;
        bus.RXFINISHED = 1'b1; cyc(); bus.RXFINISHED = 1'b0; #1;
        checks++; if (bus.FIFO_WRITE !== 1'b1 || bus.FIFO_WDATA !== 11'h00F) begin errors++; $display("FAIL rp_idle got %b/%h want 1/00f", bus.FIFO_WRITE, bus.FIFO_WDATA); end
        cyc();
    endtask

    initial begin
        bus.RX_EN = 1'b1; bus.BAUDCE = 1'b0; bus.RXFINISHED = 1'b0;
        bus.DOUT = '0; bus.PE = 1'b0; bus.FE = 1'b0; bus.BI = 1'b0;
        bus.WLS = 2'b11; bus.STB = 1'b0; bus.PEN = 1'b0;
        bus.FIFO_EN = 1'b1; bus.RXTRIG = 2'b00; bus.FIFO_USAGE = '0;
        bus.FIFO_READ = 1'b0; bus.LSR_READ = 1'b0;
        test_reset();
        test_push_basic();
        test_push_random();
        test_overrun();
        test_rda();
        test_timeout();
        test_timeout_random();
        test_write_restart();
        test_rx_disable();
        test_reset_in_push();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
